ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Sequencer and two-port arbiter in front of `random_access_memory`. Shares the RAM between an instruction-fetch port (port 0, read-only) and a data port (port 1, read/write). Converts each accepted request into the RAM's set_address / set / enable strobe sequence and returns a one-cycle acknowledge carrying the read data. Sits between the CPU control unit and the RAM instance.

## Interface
- `SIZE`, 16, data word width (matches RAM `SIZE`)
- `MAR_SIZE`, 8, address width (matches RAM `MAR_SIZE`)

- `clk`  in  1  single system clock, rising edge
- `rst_b`  in  1  asynchronous, active-low reset
- `p0_valid`  in  1  fetch request
- `p0_addr`  in  MAR_SIZE  fetch address
- `p0_ready`  out  1  fetch request accepted this cycle
- `p0_ack`  out  1  one-cycle pulse, fetch complete
- `p0_rdata`  out  SIZE  fetch data, valid while `p0_ack`=1 and held until the next port-0 read ack
- `p1_valid`  in  1  data request
- `p1_we`  in  1  1 = write, 0 = read
- `p1_addr`  in  MAR_SIZE  data address
- `p1_wdata`  in  SIZE  write data
- `p1_ready`  out  1  data request accepted this cycle
- `p1_ack`  out  1  one-cycle pulse, read or write complete
- `p1_rdata`  out  SIZE  read data, valid while `p1_ack`=1; unchanged by writes
- `ram_address`  out  MAR_SIZE  to RAM `address`
- `ram_set_address`  out  1  to RAM `set_address`
- `ram_set`  out  1  to RAM `set` (write strobe)
- `ram_enable`  out  1  to RAM `enable` (read strobe)
- `ram_data_in`  out  SIZE  to RAM `data_in`
- `ram_data_out`  in  SIZE  from RAM `data_out`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM: IDLE → ADDR → ACCESS → DONE → IDLE. No other transitions except reset.
- IDLE: `pN_ready` is combinational from both valids, the FSM state, and the arbitration pointer. A transfer occurs on `pN_valid && pN_ready`. At most one ready is high per cycle. On transfer, address, we, and wdata are latched; go to ADDR. Port 0 we is forced 0.
- ADDR: `ram_address`=latched addr, `ram_set_address`=1.
- ACCESS: address held; write → `ram_set`=1, `ram_data_in`=wdata; read → `ram_enable`=1, and `ram_data_out` is registered at the end of the cycle.
- DONE: `pN_ack`=1 for the served port; `pN_rdata` updates on reads only. All RAM strobes are 0.
- Arbitration when both ports are valid in IDLE: round-robin on a last-served pointer (see Configuration). With a single valid port, that port is served immediately.
- Requesters must not make `valid` depend on `ready`. Deasserting `valid` after a transfer has no effect; the transaction completes.
- `busy`=1 in ADDR, ACCESS, and DONE; `ready` is 0 in those states.

## Timing
- Transfer in cycle N (IDLE); ADDR in N+1; ACCESS in N+2; ack in N+3; IDLE again in N+4. Throughput is one access per 4 cycles.
- All RAM-side outputs and acks are registered; only `pN_ready` is combinational.
- Reset values: state IDLE; `ram_address`=0, `ram_data_in`=0, all strobes 0; `p0_ack`=`p1_ack`=0; `p0_rdata`=`p1_rdata`=0; `busy`=0; last-served pointer = port 1.
- Reset mid-operation forces all outputs to their reset values asynchronously. The aborted transaction gets no ack. A write aborted during ACCESS leaves the RAM word undefined. The first IDLE after reset release accepts requests.
- Addresses are used as-is; there is no wrap or range check, and the full 2^MAR_SIZE space is reachable.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: on conflict, serve the port not served last. The pointer updates on every transfer. After reset, port 0 wins the first conflict.
- Not defined: fixed priority, port 1 always wins a conflict, and the pointer logic is not built. Port 0 can starve under continuous port-1 traffic; this is accepted.

## Structure
- Package `ram_arb_pkg`:
  - state encoding IDLE=2'd0, ADDR=2'd1, ACCESS=2'd2, DONE=2'd3
  - port ids PORT_FETCH=1'b0, PORT_DATA=1'b1
- Sub-module `ram_arb_grant`: combinational grant selection plus the pointer register (pointer present only with the macro). The top level holds the FSM, request latches, and RAM drive.

## Test plan
- Port 1 writes 0xABCD to address 0 after reset → N+1: `ram_set_address`=1, `ram_address`=0; N+2: `ram_set`=1, `ram_data_in`=0xABCD; N+3: `p1_ack`=1.
- Port 0 reads address 0 → N+2: `ram_enable`=1; N+3: `p0_ack`=1, `p0_rdata`=0xABCD; `p1_rdata` unchanged.
- Port 1 writes 0xFFFF to address 2 and 0x0000 to address 3, then reads both back → `p1_rdata` = 0xFFFF then 0x0000; acks spaced exactly 4 cycles.
- Both ports valid in the same IDLE cycle with reads of address 0 and address 2:
  - with `RAM_ARB_ROUND_ROBIN_EN`: port 0 is acked first, port 1 four cycles later;
  - without it: port 1 first.
- `rst_b` pulled low during the ACCESS of a port-1 write → strobes and `busy` drop to 0 immediately, and no `p1_ack`. After release, a port-0 request is accepted on the first cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state encoding and port ids for the RAM access arbiter
package ram_arb_pkg;

   // Sequencer states: one RAM access takes exactly four cycles
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

   // Requester identities, also the encoding of the last-served pointer
   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/ram_arb_grant.sv
// rtl/ram_arb_grant.sv - grant selection; round-robin pointer only with RAM_ARB_ROUND_ROBIN_EN
module ram_arb_grant
   import ram_arb_pkg::*;
(
`ifdef RAM_ARB_ROUND_ROBIN_EN
   input  logic clk_i,
   input  logic rst_b_i,
`endif
   input  logic idle_i,
   input  logic p0_valid_i,
   input  logic p1_valid_i,
   output logic p0_ready_o,
   output logic p1_ready_o
);

   logic prefer_p0;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_q;
   logic last_d;

   // On a conflict the port that was not served last wins
   assign prefer_p0 = (last_q == PORT_DATA);

   // Pointer follows every transfer, whether or not it was contested
   always_comb begin
      last_d = last_q;
      if (p0_ready_o) begin
         last_d = PORT_FETCH;
      end else if (p1_ready_o) begin
         last_d = PORT_DATA;
      end
   end

   // Pointer register; starts as "data port served last" so fetch wins the first conflict
   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         last_q <= PORT_DATA;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: the data port always wins a conflict
   assign prefer_p0 = 1'b0;
`endif

   // At most one ready, only while idle; a lone requester is served immediately
   always_comb begin
      p0_ready_o = idle_i && p0_valid_i && (!p1_valid_i || prefer_p0);
      p1_ready_o = idle_i && p1_valid_i && (!p0_valid_i || !prefer_p0);
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - two-port RAM sequencer/arbiter; RAM_ARB_ROUND_ROBIN_EN selects round-robin
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int SIZE     = 16,
   parameter int MAR_SIZE = 8
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                p0_valid,
   input  logic [MAR_SIZE-1:0] p0_addr,
   output logic                p0_ready,
   output logic                p0_ack,
   output logic [SIZE-1:0]     p0_rdata,
   input  logic                p1_valid,
   input  logic                p1_we,
   input  logic [MAR_SIZE-1:0] p1_addr,
   input  logic [SIZE-1:0]     p1_wdata,
   output logic                p1_ready,
   output logic                p1_ack,
   output logic [SIZE-1:0]     p1_rdata,
   output logic [MAR_SIZE-1:0] ram_address,
   output logic                ram_set_address,
   output logic                ram_set,
   output logic                ram_enable,
   output logic [SIZE-1:0]     ram_data_in,
   input  logic [SIZE-1:0]     ram_data_out,
   output logic                busy
);

   arb_state_e          state_q;
   logic                port_q;
   logic                we_q;
   logic [SIZE-1:0]     wdata_q;
   logic [MAR_SIZE-1:0] ram_address_q;
   logic                ram_set_address_q;
   logic                ram_set_q;
   logic                ram_enable_q;
   logic [SIZE-1:0]     ram_data_in_q;
   logic                p0_ack_q;
   logic                p1_ack_q;
   logic [SIZE-1:0]     p0_rdata_q;
   logic [SIZE-1:0]     p1_rdata_q;

   ram_arb_grant u_grant (
`ifdef RAM_ARB_ROUND_ROBIN_EN
      .clk_i      (clk),
      .rst_b_i    (rst_b),
`endif
      .idle_i     (state_q == IDLE),
      .p0_valid_i (p0_valid),
      .p1_valid_i (p1_valid),
      .p0_ready_o (p0_ready),
      .p1_ready_o (p1_ready)
   );

   // Sequencer: latch the granted request, then drive set_address, set/enable, ack in turn
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q           <= IDLE;
         port_q            <= PORT_DATA;
         we_q              <= 1'b0;
         wdata_q           <= '0;
         ram_address_q     <= '0;
         ram_set_address_q <= 1'b0;
         ram_set_q         <= 1'b0;
         ram_enable_q      <= 1'b0;
         ram_data_in_q     <= '0;
         p0_ack_q          <= 1'b0;
         p1_ack_q          <= 1'b0;
         p0_rdata_q        <= '0;
         p1_rdata_q        <= '0;
      end else begin
         // Strobes and acks are single-cycle pulses unless a state below raises them
         ram_set_address_q <= 1'b0;
         ram_set_q         <= 1'b0;
         ram_enable_q      <= 1'b0;
         p0_ack_q          <= 1'b0;
         p1_ack_q          <= 1'b0;
         case (state_q)
            IDLE: begin
               if (p0_ready || p1_ready) begin
                  // The fetch port is read-only, so its we is forced low
                  port_q            <= p1_ready ? PORT_DATA : PORT_FETCH;
                  we_q              <= p1_ready & p1_we;
                  wdata_q           <= p1_wdata;
                  ram_address_q     <= p1_ready ? p1_addr : p0_addr;
                  ram_set_address_q <= 1'b1;
                  state_q           <= ADDR;
               end
            end
            ADDR: begin
               if (we_q) begin
                  ram_set_q     <= 1'b1;
                  ram_data_in_q <= wdata_q;
               end else begin
                  ram_enable_q  <= 1'b1;
               end
               state_q <= ACCESS;
            end
            ACCESS: begin
               // Read data is captured at the end of the enable cycle, together with the ack
               if (port_q == PORT_FETCH) begin
                  p0_ack_q <= 1'b1;
                  if (!we_q) begin
                     p0_rdata_q <= ram_data_out;
                  end
               end else begin
                  p1_ack_q <= 1'b1;
                  if (!we_q) begin
                     p1_rdata_q <= ram_data_out;
                  end
               end
               state_q <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ram_address     = ram_address_q;
   assign ram_set_address = ram_set_address_q;
   assign ram_set         = ram_set_q;
   assign ram_enable      = ram_enable_q;
   assign ram_data_in     = ram_data_in_q;
   assign p0_ack          = p0_ack_q;
   assign p1_ack          = p1_ack_q;
   assign p0_rdata        = p0_rdata_q;
   assign p1_rdata        = p1_rdata_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - randomized self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;

   logic        clk;
   logic        rst_b;
   logic        p0_valid;
   logic [7:0]  p0_addr;
   logic        p0_ready;
   logic        p0_ack;
   logic [15:0] p0_rdata;
   logic        p1_valid;
   logic        p1_we;
   logic [7:0]  p1_addr;
   logic [15:0] p1_wdata;
   logic        p1_ready;
   logic        p1_ack;
   logic [15:0] p1_rdata;
   logic [7:0]  ram_address;
   logic        ram_set_address;
   logic        ram_set;
   logic        ram_enable;
   logic [15:0] ram_data_in;
   logic [15:0] ram_data_out;
   logic        busy;

   int errors;
   int checks;

   logic [15:0] ram_mem [256];
   logic [15:0] mdl_mem [256];
   logic        mdl_last;
   logic [15:0] exp_rd0;
   logic [15:0] exp_rd1;

   ram_access_arbiter #(.SIZE(16), .MAR_SIZE(8)) dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .p0_valid        (p0_valid),
      .p0_addr         (p0_addr),
      .p0_ready        (p0_ready),
      .p0_ack          (p0_ack),
      .p0_rdata        (p0_rdata),
      .p1_valid        (p1_valid),
      .p1_we           (p1_we),
      .p1_addr         (p1_addr),
      .p1_wdata        (p1_wdata),
      .p1_ready        (p1_ready),
      .p1_ack          (p1_ack),
      .p1_rdata        (p1_rdata),
      .ram_address     (ram_address),
      .ram_set_address (ram_set_address),
      .ram_set         (ram_set),
      .ram_enable      (ram_enable),
      .ram_data_in     (ram_data_in),
      .ram_data_out    (ram_data_out),
      .busy            (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Simple RAM stub: write on set, combinational read gated by enable
   assign ram_data_out = ram_enable ? ram_mem[ram_address] : 16'h0000;

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
      forever begin
         @(negedge clk);
         if (ram_set) ram_mem[ram_address] = ram_data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic noise();
      p0_valid = 1'($urandom);
      p0_addr  = 8'($urandom);
      p1_valid = 1'($urandom);
      p1_we    = 1'($urandom);
      p1_addr  = 8'($urandom);
      p1_wdata = 16'($urandom);
   endtask

   task automatic do_txn(input logic v0, input logic [7:0] a0, input logic v1,
                         input logic we1, input logic [7:0] a1, input logic [15:0] wd1);
      int          win;
      logic [7:0]  a;
      logic        we;
      @(negedge clk);
      p0_valid = v0;
      p0_addr  = a0;
      p1_valid = v1;
      p1_we    = we1;
      p1_addr  = a1;
      p1_wdata = wd1;
      #1;
      if (v0 && v1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         win = (mdl_last == 1'b1) ? 0 : 1;
`else
         win = 1;
`endif
      end else if (v0) begin
         win = 0;
      end else if (v1) begin
         win = 1;
      end else begin
         win = -1;
      end
      chk("idle_busy", 32'(busy), 0);
      chk("p0_ready", 32'(p0_ready), 32'(win == 0));
      chk("p1_ready", 32'(p1_ready), 32'(win == 1));
      chk("idle_acks", 32'({p0_ack, p1_ack}), 0);
      if (win < 0) return;

      mdl_last = (win == 1);
      a  = (win == 1) ? a1 : a0;
      we = (win == 1) && we1;
      if (we) mdl_mem[a] = wd1;
      else if (win == 0) exp_rd0 = mdl_mem[a];
      else exp_rd1 = mdl_mem[a];

      @(negedge clk);
      noise();
      #1;
      chk("addr_busy", 32'(busy), 1);
      chk("addr_set_address", 32'(ram_set_address), 1);
      chk("addr_address", 32'(ram_address), 32'(a));
      chk("addr_strobes", 32'({ram_set, ram_enable}), 0);
      chk("addr_ready", 32'({p0_ready, p1_ready}), 0);
      chk("addr_acks", 32'({p0_ack, p1_ack}), 0);

      @(negedge clk);
      noise();
      #1;
      chk("acc_set", 32'(ram_set), 32'(we));
      chk("acc_enable", 32'(ram_enable), 32'(!we));
      chk("acc_set_address", 32'(ram_set_address), 0);
      chk("acc_address", 32'(ram_address), 32'(a));
      if (we) chk("acc_data_in", 32'(ram_data_in), 32'(wd1));
      chk("acc_ready", 32'({p0_ready, p1_ready}), 0);
      chk("acc_acks", 32'({p0_ack, p1_ack}), 0);

      @(negedge clk);
      noise();
      #1;
      chk("done_p0_ack", 32'(p0_ack), 32'(win == 0));
      chk("done_p1_ack", 32'(p1_ack), 32'(win == 1));
      chk("done_p0_rdata", 32'(p0_rdata), 32'(exp_rd0));
      chk("done_p1_rdata", 32'(p1_rdata), 32'(exp_rd1));
      chk("done_strobes", 32'({ram_set_address, ram_set, ram_enable}), 0);
      chk("done_busy", 32'(busy), 1);
      chk("done_ready", 32'({p0_ready, p1_ready}), 0);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst_b    = 1'b0;
      p0_valid = 1'b0;
      p0_addr  = 8'h00;
      p1_valid = 1'b0;
      p1_we    = 1'b0;
      p1_addr  = 8'h00;
      p1_wdata = 16'h0000;
      for (int i = 0; i < 256; i++) mdl_mem[i] = 16'h0000;
      mdl_last = 1'b1;
      exp_rd0  = 16'h0000;
      exp_rd1  = 16'h0000;

      #3;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strobes", 32'({ram_set_address, ram_set, ram_enable}), 0);
      chk("rst_address", 32'(ram_address), 0);
      chk("rst_data_in", 32'(ram_data_in), 0);
      chk("rst_acks", 32'({p0_ack, p1_ack}), 0);
      chk("rst_p0_rdata", 32'(p0_rdata), 0);
      chk("rst_p1_rdata", 32'(p1_rdata), 0);
      @(posedge clk);
      #1 rst_b = 1'b1;

      // Directed sequences
      do_txn(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'hABCD);
      do_txn(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
      do_txn(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 16'hFFFF);
      do_txn(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 16'h0000);
      do_txn(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 16'h1111);
      do_txn(1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 16'h2222);
      do_txn(1'b1, 8'h00, 1'b1, 1'b0, 8'h02, 16'h0000);
      do_txn(1'b1, 8'h00, 1'b1, 1'b0, 8'h02, 16'h0000);
      do_txn(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 16'h5A5A);
      do_txn(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 16'h0000);
      do_txn(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);

      // Random traffic
      for (int t = 0; t < 300; t++) begin
         do_txn(1'($urandom_range(0, 3) != 0), 8'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 16'($urandom));
      end

      // Reset during the ACCESS cycle of a data-port write
      @(negedge clk);
      p0_valid = 1'b0;
      p1_valid = 1'b1;
      p1_we    = 1'b1;
      p1_addr  = 8'h05;
      p1_wdata = 16'h1234;
      #1 chk("ar_ready", 32'(p1_ready), 1);
      @(negedge clk);
      p1_valid = 1'b0;
      #1 chk("ar_set_address", 32'(ram_set_address), 1);
      @(negedge clk);
      #1 chk("ar_pre_set", 32'(ram_set), 1);
      #2 rst_b = 1'b0;
      #1;
      chk("ar_strobes", 32'({ram_set_address, ram_set, ram_enable}), 0);
      chk("ar_busy", 32'(busy), 0);
      chk("ar_address", 32'(ram_address), 0);
      chk("ar_data_in", 32'(ram_data_in), 0);
      chk("ar_rdata", 32'({p0_rdata, p1_rdata}), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("ar_no_ack", 32'({p0_ack, p1_ack}), 0);
         chk("ar_held_busy", 32'(busy), 0);
      end
      mdl_last = 1'b1;
      exp_rd0  = 16'h0000;
      exp_rd1  = 16'h0000;
      @(posedge clk);
      #1 rst_b = 1'b1;
      do_txn(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
      do_txn(1'b1, 8'h02, 1'b1, 1'b0, 8'h03, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
